output_port_bank: RTL and testbench

OUTPUT_PORT_BANK -- requirements
Module: output_port_bank

---
 rtl/output_port_bank_pkg.sv | 19 +
 rtl/wr_fifo.sv | 52 +++++
 rtl/output_port_bank.sv | 86 ++++++++
 tb/tb_output_port_bank.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/output_port_bank_pkg.sv
// Shared types and constants for the output port bank: drain FSM encoding,
// port count and the layout of one buffered write.
package output_port_bank_pkg;

  localparam int NUM_PORTS = 4;
  localparam int ENTRY_W   = 10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    COMMIT = 2'd1,
    HOLD   = 2'd2
  } drain_state_t;

  typedef struct packed {
    logic [1:0] port;
    logic [7:0] data;
  } wr_entry_t;

endpackage

// File: rtl/wr_fifo.sv
// Write buffer: power-of-two circular FIFO with occupancy counter.
// A push while full is accepted only if a pop happens on the same edge.
module wr_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 10
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic             do_push, do_pop;

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge Clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/output_port_bank.sv
// Four memory-mapped 8-bit output ports behind a write buffer; a drain FSM
// commits one buffered write at a time and strobes the written port.
import output_port_bank_pkg::*;

module output_port_bank #(
  parameter logic [7:0] BASE_ADDR     = 8'hF0,
  parameter int         FIFO_DEPTH    = 4,
  parameter int         STROBE_CYCLES = 2
) (
  input  logic                     Clk,
  input  logic                     Rst,
  input  logic [7:0]               DataOut_Bus,
  input  logic [7:0]               Addres_Data_Bus,
  input  logic                     LE,
  input  logic                     Drain_En,
  input  logic                     Ovf_Clr,
  output logic [8*NUM_PORTS-1:0]   Port_Out,
  output logic [NUM_PORTS-1:0]     Port_Strobe,
  output logic                     Fifo_Full,
  output logic                     Overflow,
  output logic                     Busy
);

  localparam logic [3:0] STB_LEN = 4'(STROBE_CYCLES);

  drain_state_t state, state_nxt;
  wr_entry_t    wr_in, head, cur;
  logic         in_win, pop, ovf_evt;
  logic         fifo_full, fifo_empty;
  logic [3:0]   hold_cnt;

  assign in_win  = LE && (Addres_Data_Bus[7:2] == BASE_ADDR[7:2]);
  assign pop     = (state == IDLE) && !fifo_empty && Drain_En;
  assign ovf_evt = in_win && fifo_full && !pop;
  assign wr_in   = '{port: Addres_Data_Bus[1:0], data: DataOut_Bus};

  wr_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(ENTRY_W)) u_fifo (
    .Clk   (Clk),
    .Rst   (Rst),
    .push  (in_win),
    .pop   (pop),
    .din   (wr_in),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign Fifo_Full = fifo_full;
  assign Busy      = !fifo_empty || (state != IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pop) state_nxt = COMMIT;
      COMMIT:  state_nxt = (STROBE_CYCLES > 1) ? HOLD : IDLE;
      HOLD:    if (hold_cnt == 4'd1) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // hold_cnt times the strobe itself, so a falling Drain_En cannot cut it short.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state       <= IDLE;
      cur         <= '0;
      hold_cnt    <= '0;
      Port_Out    <= '0;
      Port_Strobe <= '0;
      Overflow    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (pop) cur <= head;
      if (state == COMMIT) begin
        Port_Out[8*int'(cur.port) +: 8] <= cur.data;
        Port_Strobe <= 4'b0001 << cur.port;
        hold_cnt    <= STB_LEN;
      end else if (hold_cnt != '0) begin
        hold_cnt <= hold_cnt - 1'b1;
        if (hold_cnt == 4'd1) Port_Strobe <= '0;
      end
      if (ovf_evt)      Overflow <= 1'b1;
      else if (Ovf_Clr) Overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_output_port_bank.sv
// Scoreboard bench: stimulus queues expected commits, a negedge monitor
// checks each strobe against the queue and checks strobe width.
module tb_output_port_bank;

  typedef struct {
    logic [1:0] port;
    logic [7:0] data;
  } exp_t;

  logic        Clk, Rst;
  logic [7:0]  DataOut_Bus, Addres_Data_Bus;
  logic        LE, Drain_En, Ovf_Clr;
  logic [31:0] Port_Out;
  logic [3:0]  Port_Strobe;
  logic        Fifo_Full, Overflow, Busy;

  int   checks = 0;
  int   errors = 0;
  int   ncommit = 0;
  exp_t exp_q[$];

  output_port_bank #(.BASE_ADDR(8'hF0), .FIFO_DEPTH(4), .STROBE_CYCLES(2)) dut (
    .Clk(Clk), .Rst(Rst), .DataOut_Bus(DataOut_Bus), .Addres_Data_Bus(Addres_Data_Bus),
    .LE(LE), .Drain_En(Drain_En), .Ovf_Clr(Ovf_Clr), .Port_Out(Port_Out),
    .Port_Strobe(Port_Strobe), .Fifo_Full(Fifo_Full), .Overflow(Overflow), .Busy(Busy)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: every rising strobe is one commit, checked against the queue head.
  logic [3:0] prev_stb;
  int         width;
  always @(negedge Clk) begin
    exp_t e;
    if (Rst) begin
      prev_stb = '0;
      width    = 0;
    end else begin
      if (Port_Strobe != 4'b0 && prev_stb == 4'b0) begin
        ncommit++;
        width = 1;
        if (exp_q.size() == 0) begin
          chk("unexpected_commit", {28'b0, Port_Strobe}, 32'h0);
        end else begin
          e = exp_q.pop_front();
          chk("commit_strobe", {28'b0, Port_Strobe}, 32'(4'b0001 << e.port));
          chk("commit_data", {24'b0, Port_Out[8*int'(e.port) +: 8]}, {24'b0, e.data});
        end
      end else if (Port_Strobe != 4'b0) begin
        width++;
      end else if (prev_stb != 4'b0) begin
        chk("strobe_width", width, 2);
      end
      prev_stb = Port_Strobe;
    end
  end

  task automatic drive(input logic [7:0] a, input logic [7:0] d, input logic expect_commit);
    exp_t e;
    @(posedge Clk); #1;
    Addres_Data_Bus = a; DataOut_Bus = d; LE = 1'b1;
    if (expect_commit) begin
      e.port = a[1:0]; e.data = d;
      exp_q.push_back(e);
    end
  endtask

  task automatic idle();
    @(posedge Clk); #1;
    LE = 1'b0;
  endtask

  // Single write into an empty FIFO with Drain_En=1: data visible after edge N+2.
  task automatic wr_lat(input logic [7:0] a, input logic [7:0] d,
                        input logic [31:0] po_before, input logic [31:0] po_after);
    logic [1:0] p;
    p = a[1:0];
    drive(a, d, 1'b1);
    idle();                                   // edge N has sampled the write
    @(negedge Clk);
    chk("lat_n0_busy", {31'b0, Busy}, 32'h1);
    chk("lat_n0_strobe", {28'b0, Port_Strobe}, 32'h0);
    @(negedge Clk);                           // after N+1: popped, not yet visible
    chk("lat_n1_port_out", Port_Out, po_before);
    @(negedge Clk);                           // after N+2
    chk("lat_n2_port_out", Port_Out, po_after);
    chk("lat_n2_strobe", {28'b0, Port_Strobe}, 32'(4'b0001 << p));
    @(negedge Clk);
    chk("lat_n3_strobe", {28'b0, Port_Strobe}, 32'(4'b0001 << p));
    @(negedge Clk);
    chk("lat_n4_strobe_off", {28'b0, Port_Strobe}, 32'h0);
    chk("lat_n4_busy", {31'b0, Busy}, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    Rst = 1'b1; LE = 1'b0; Drain_En = 1'b0; Ovf_Clr = 1'b0;
    DataOut_Bus = '0; Addres_Data_Bus = '0;
    #3;
    chk("rst_port_out", Port_Out, 32'h0);
    chk("rst_flags", {28'b0, Fifo_Full, Overflow, Busy, |Port_Strobe}, 32'h0);
    @(posedge Clk); @(posedge Clk); #1;
    Rst = 1'b0;
    Drain_En = 1'b1;

    // Basic write to port 2 with latency and strobe length
    wr_lat(8'hF2, 8'h5A, 32'h0, 32'h005A_0000);

    // Out-of-window write is ignored
    drive(8'h37, 8'hFF, 1'b0);
    idle();
    repeat (3) @(negedge Clk);
    chk("oow_busy", {31'b0, Busy}, 32'h0);
    chk("oow_port_out", Port_Out, 32'h005A_0000);
    chk("oow_ovf", {31'b0, Overflow}, 32'h0);

    // Fill with drain stalled, fifth write overflows, then clear
    Drain_En = 1'b0;
    drive(8'hF0, 8'hA1, 1'b1);
    drive(8'hF1, 8'hA2, 1'b1);
    drive(8'hF2, 8'hA3, 1'b1);
    drive(8'hF3, 8'hA4, 1'b1);
    drive(8'hF3, 8'hA5, 1'b0);
    @(negedge Clk);
    chk("fill_full", {31'b0, Fifo_Full}, 32'h1);
    chk("fill_no_ovf_yet", {31'b0, Overflow}, 32'h0);
    idle();
    @(negedge Clk);
    chk("fill_ovf", {31'b0, Overflow}, 32'h1);
    chk("fill_busy", {31'b0, Busy}, 32'h1);
    @(posedge Clk); #1 Ovf_Clr = 1'b1;
    @(posedge Clk); #1 Ovf_Clr = 1'b0;
    @(negedge Clk);
    chk("ovf_clr", {31'b0, Overflow}, 32'h0);

    // Full FIFO: push and pop on the same edge
    @(posedge Clk); #1;
    Drain_En = 1'b1;
    begin
      exp_t e;
      Addres_Data_Bus = 8'hF1; DataOut_Bus = 8'hB6; LE = 1'b1;
      e.port = 2'd1; e.data = 8'hB6;
      exp_q.push_back(e);
    end
    idle();
    @(negedge Clk);
    chk("pushpop_full", {31'b0, Fifo_Full}, 32'h1);
    chk("pushpop_no_ovf", {31'b0, Overflow}, 32'h0);
    repeat (25) @(negedge Clk);
    chk("pushpop_drained", {31'b0, Busy}, 32'h0);
    chk("pushpop_port_out", Port_Out, 32'hA4A3_B6A1);
    chk("pushpop_ovf_end", {31'b0, Overflow}, 32'h0);

    // Two writes to port 0: two separate strobes, last wins
    n0 = ncommit;
    drive(8'hF0, 8'h11, 1'b1);
    drive(8'hF0, 8'h22, 1'b1);
    idle();
    repeat (15) @(negedge Clk);
    chk("same_port_commits", ncommit - n0, 2);
    chk("same_port_last", Port_Out, 32'hA4A3_B622);

    // Reset during HOLD with three entries still buffered
    Drain_En = 1'b0;
    drive(8'hF0, 8'hC1, 1'b1);
    drive(8'hF1, 8'hC2, 1'b1);
    drive(8'hF2, 8'hC3, 1'b1);
    drive(8'hF3, 8'hC4, 1'b1);
    idle();
    @(posedge Clk); #1 Drain_En = 1'b1;
    @(posedge Clk);                           // pop C1
    @(posedge Clk);                           // commit C1
    @(negedge Clk);
    chk("hold_strobe", {28'b0, Port_Strobe}, 32'h1);
    @(posedge Clk); #2;
    Rst = 1'b1;
    exp_q.delete();
    #1;
    chk("midrst_port_out", Port_Out, 32'h0);
    chk("midrst_flags", {28'b0, Fifo_Full, Overflow, Busy, |Port_Strobe}, 32'h0);
    @(negedge Clk);
    @(posedge Clk); #1 Rst = 1'b0;
    n0 = ncommit;
    repeat (15) @(negedge Clk);
    chk("postrst_no_commit", ncommit - n0, 0);
    chk("postrst_port_out", Port_Out, 32'h0);
    chk("postrst_busy", {31'b0, Busy}, 32'h0);

    // First write after reset has the normal latency
    wr_lat(8'hF3, 8'hD7, 32'h0, 32'hD700_0000);

    repeat (3) @(negedge Clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
